sr_latch_driver: RTL and testbench



---
 rtl/sr_pkg.sv | 12 +
 rtl/sr_sync2.sv | 13 +
 rtl/sr_latch_driver.sv | 109 ++++++++++
 tb/tb_sr_latch_driver.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// sr_pkg: shared FSM type, op encodings and counter sizing for the SR latch driver.
package sr_pkg;
    typedef enum logic [2:0] {IDLE, PULSE, SETTLE, CHECK, DEAD} sr_state_e;
    localparam logic OP_CLR = 1'b0;
    localparam logic OP_SET = 1'b1;
    function automatic int cnt_width(input int pulse_w, input int settle_w, input int dead_w);
        int m;
        m = (pulse_w > settle_w) ? pulse_w : settle_w;
        m = (m > dead_w) ? m : dead_w;
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/sr_sync2.sv
// sr_sync2: two-flop synchronizer for an asynchronous level, reset to 0.
module sr_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    always_ff @(posedge clk) begin
        if (rst) {q_o, meta_q} <= 2'b00;
        else     {q_o, meta_q} <= {meta_q, d_i};
    end
endmodule

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: drives width-controlled active-low pulses into an external NAND SR latch,
// enforces settle/dead time and verifies the synchronized Q/notQ readback.
module sr_latch_driver
    import sr_pkg::*;
#(
    parameter int PULSE_W  = 4,
    parameter int SETTLE_W = 2,
    parameter int DEAD_W   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_op,
    output logic req_ready,
    output logic set_n,
    output logic clr_n,
    input  logic q,
    input  logic q_n,
    output logic done,
    output logic err,
    output logic state_q,
    output logic state_vld
);
    localparam int CNT_W = cnt_width(PULSE_W, SETTLE_W, DEAD_W);
    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_W - 1);
    localparam logic [CNT_W-1:0] DEAD_LD   = CNT_W'((DEAD_W > 0) ? DEAD_W - 1 : 0);

    sr_state_e fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic op_q, op_d, set_n_d, clr_n_d, done_d, err_d, state_d, vld_d;
    logic qs, qns, cnt_zero, bad;

    sr_sync2 u_sync_q  (.clk(clk), .rst(rst), .d_i(q),   .q_o(qs));
    sr_sync2 u_sync_qn (.clk(clk), .rst(rst), .d_i(q_n), .q_o(qns));

    assign req_ready = (fsm_q == IDLE) && !rst;
    assign cnt_zero  = cnt_q == '0;
    // Both readbacks equal means the latch is in a forbidden or broken state.
    assign bad       = (qs == qns) || (qs != op_q);

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_zero ? '0 : cnt_q - CNT_W'(1);
        op_d    = op_q;
        set_n_d = 1'b1;
        clr_n_d = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;
        state_d = state_q;
        vld_d   = state_vld;
        case (fsm_q)
            IDLE: begin
                if (req_valid) begin
                    fsm_d   = PULSE;
                    cnt_d   = PULSE_LD;
                    op_d    = req_op;
                    set_n_d = req_op != OP_SET;
                    clr_n_d = req_op != OP_CLR;
                end
            end
            PULSE: begin
                fsm_d   = cnt_zero ? SETTLE : PULSE;
                cnt_d   = cnt_zero ? SETTLE_LD : cnt_q - CNT_W'(1);
                set_n_d = cnt_zero || op_q != OP_SET;
                clr_n_d = cnt_zero || op_q != OP_CLR;
            end
            SETTLE: begin
                if (cnt_zero) begin
                    fsm_d   = CHECK;
                    done_d  = 1'b1;
                    err_d   = bad;
                    state_d = bad ? state_q : op_q;
                    vld_d   = !bad;
                end
            end
            CHECK: begin
                fsm_d = (DEAD_W == 0) ? IDLE : DEAD;
                cnt_d = DEAD_LD;
            end
            DEAD: fsm_d = cnt_zero ? IDLE : DEAD;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= IDLE;
            cnt_q     <= '0;
            op_q      <= OP_CLR;
            set_n     <= 1'b1;
            clr_n     <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            state_q   <= 1'b0;
            state_vld <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            set_n     <= set_n_d;
            clr_n     <= clr_n_d;
            done      <= done_d;
            err       <= err_d;
            state_q   <= state_d;
            state_vld <= vld_d;
        end
    end
endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: NAND latch model plus a timeline-based reference for the SR latch driver.
module tb_sr_latch_driver;
    import sr_pkg::*;
    localparam int P = 4, S = 2, D = 2;

    logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_op = 1'b0;
    logic req_ready, set_n, clr_n, q, q_n, done, err, state_q, state_vld;
    logic lat = 1'b0;
    int mode = 0;
    int checks = 0, errors = 0;
    int j = -1;
    logic m_op = 1'b0, m_err = 1'b0, m_st = 1'b0, m_vld = 1'b0;

    always #5 clk = ~clk;

    sr_latch_driver #(.PULSE_W(P), .SETTLE_W(S), .DEAD_W(D)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
        .set_n(set_n), .clr_n(clr_n), .q(q), .q_n(q_n), .done(done), .err(err),
        .state_q(state_q), .state_vld(state_vld)
    );

    // Latch model: mode 0 healthy, 1 Q stuck at 0, 2 both outputs high.
    always @(set_n or clr_n) begin
        if (!set_n && clr_n) lat = 1'b1;
        else if (set_n && !clr_n) lat = 1'b0;
    end
    assign q   = ((!set_n && !clr_n) || mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : lat;
    assign q_n = ((!set_n && !clr_n) || mode == 2) ? 1'b1 : (mode == 1) ? 1'b1 : !lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: j counts edges since acceptance; every output follows from where j sits in the command timeline.
    always @(posedge clk) begin
        if (rst) begin
            j = -1;
            m_st = 1'b0;
            m_vld = 1'b0;
        end else if (j >= 0 && j < P + S + D) j++;
        else if (j < 0 && req_valid) begin
            j = 0;
            m_op = req_op;
        end else j = -1;
        if (j == P + S) begin
            m_err = (mode == 2) || (mode == 1 && m_op == OP_SET);
            m_vld = !m_err;
            if (!m_err) m_st = m_op;
        end
        #1;
        chk("req_ready", req_ready, j < 0 && !rst);
        chk("set_n", set_n, !(j >= 0 && j < P && m_op == OP_SET));
        chk("clr_n", clr_n, !(j >= 0 && j < P && m_op == OP_CLR));
        chk("overlap", set_n | clr_n, 1);
        chk("done", done, j == P + S);
        chk("err", err, j == P + S && m_err);
        chk("state_q", state_q, m_st);
        chk("state_vld", state_vld, m_vld);
    end

    task automatic cmd(input logic op, input int fm, input logic e_err, input logic e_st, input logic e_vld);
        int lows, other, done_at;
        logic err_at, rdy8;
        lows = 0; other = 0; done_at = -1; err_at = 1'b0; rdy8 = 1'b1;
        @(negedge clk);
        mode = fm;
        req_valid = 1'b1;
        req_op = op;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (k == 0) req_valid = 1'b0;
            if (!(op ? set_n : clr_n)) lows++;
            if (!(op ? clr_n : set_n)) other++;
            if (done) begin
                done_at = k;
                err_at = err;
            end
            if (k == 8) rdy8 = req_ready;
        end
        chk("d_width", lows, 4);
        chk("d_other_line", other, 0);
        chk("d_done_cycle", done_at, 6);
        chk("d_err", err_at, e_err);
        chk("d_state_q", state_q, e_st);
        chk("d_state_vld", state_vld, e_vld);
        chk("d_ready_dead", rdy8, 0);
        chk("d_ready_back", req_ready, 1);
    endtask

    initial begin
        int last, acc, dn;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_set_n", set_n, 1);
        chk("rst_clr_n", clr_n, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_state_q", state_q, 0);
        chk("rst_state_vld", state_vld, 0);
        chk("rst_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", req_ready, 1);
        cmd(OP_SET, 0, 1'b0, 1'b1, 1'b1);
        cmd(OP_CLR, 0, 1'b0, 1'b0, 1'b1);
        cmd(OP_SET, 1, 1'b1, 1'b0, 1'b0);
        cmd(OP_CLR, 1, 1'b0, 1'b0, 1'b1);
        cmd(OP_SET, 0, 1'b0, 1'b1, 1'b1);
        cmd(OP_CLR, 2, 1'b1, 1'b1, 1'b0);
        cmd(OP_SET, 0, 1'b0, 1'b1, 1'b1);
        // Valid held high with alternating ops.
        @(negedge clk);
        mode = 0;
        req_valid = 1'b1;
        req_op = OP_CLR;
        last = -1;
        acc = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            if (req_ready) begin
                if (last >= 0) chk("b2b_spacing", k - last, 10);
                last = k;
                acc++;
                req_op = !req_op;
            end
        end
        chk("b2b_accepts", acc, 4);
        req_valid = 1'b0;
        repeat (12) @(posedge clk);
        // Reset during the pulse.
        @(negedge clk);
        req_valid = 1'b1;
        req_op = OP_SET;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_pulse_low", set_n, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_set_n", set_n, 1);
        chk("mid_rst_clr_n", clr_n, 1);
        chk("mid_rst_vld", state_vld, 0);
        rst = 1'b0;
        dn = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (k == 0) chk("mid_rst_ready", req_ready, 1);
            dn += int'(done);
        end
        chk("mid_rst_no_done", dn, 0);
        // Randomized traffic, faults and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            int r;
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            req_valid = 1'($urandom_range(0, 1));
            req_op = 1'($urandom_range(0, 1));
            if (j < 0) begin
                r = $urandom_range(0, 7);
                mode = (r < 6) ? 0 : (r == 6) ? 1 : 2;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
